// File: rtl/eh2_ram_be_init_if.sv
// Port bundle for eh2_ram_be_init: access request, read return and init status.
// PERR_INJ/PERR exist only when EH2_RAM_PARITY_EN is defined.
interface eh2_ram_be_init_if #(
  parameter int DEPTH     = 4096,
  parameter int WIDTH     = 39,
  parameter int MASK_GRAN = 1
);
  localparam int AW = $clog2(DEPTH);
  localparam int MW = WIDTH / MASK_GRAN;

  logic             ME;
  logic             WE;
  logic [AW-1:0]    ADR;
  logic [WIDTH-1:0] D;
  logic [MW-1:0]    WEM;
  logic [WIDTH-1:0] Q;
  logic             RD_VALID;
  logic             INIT_BUSY;
  logic             INIT_DONE;
`ifdef EH2_RAM_PARITY_EN
  logic             PERR_INJ;
  logic             PERR;

  modport master (output ME, WE, ADR, D, WEM, PERR_INJ,
                  input  Q, RD_VALID, INIT_BUSY, INIT_DONE, PERR);
  modport slave  (input  ME, WE, ADR, D, WEM, PERR_INJ,
                  output Q, RD_VALID, INIT_BUSY, INIT_DONE, PERR);
`else
  modport master (output ME, WE, ADR, D, WEM,
                  input  Q, RD_VALID, INIT_BUSY, INIT_DONE);
  modport slave  (input  ME, WE, ADR, D, WEM,
                  output Q, RD_VALID, INIT_BUSY, INIT_DONE);
`endif
endinterface

// File: rtl/eh2_ram_be_init.sv
// Single-port behavioural SRAM: masked writes, 1/2-cycle read latency, post-reset clear.
// Define EH2_RAM_PARITY_EN to store one even-parity bit per word with error reporting.
module eh2_ram_be_init #(
  parameter int               DEPTH     = 4096,
  parameter int               WIDTH     = 39,
  parameter int               MASK_GRAN = 1,
  parameter int               RD_LAT    = 1,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
  input logic              CLK,
  input logic              RST,
  eh2_ram_be_init_if.slave bus
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              MW       = WIDTH / MASK_GRAN;
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADR = AW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_e;

  function automatic logic [WIDTH-1:0] expand_mask(input logic [MW-1:0] wem);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MW; i++) m[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wem[i]}};
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] merge_word(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [WIDTH-1:0] m);
    return (old_w & ~m) | (new_w & m);
  endfunction

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             in_range;
  logic             init_wr;
  logic             acc;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] new_word;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic             vld_q;
  logic [WIDTH-1:0] q_q;

  assign in_range = {1'b0, bus.ADR} < DEPTH_W;
  assign init_wr  = !RST && (state_q == S_INIT);
  assign acc      = !RST && (state_q == S_READY) && bus.ME;
  assign wr_en    = acc && bus.WE && in_range;
  assign rd_en    = acc && !bus.WE;
  // Out-of-range addresses read as zero and never reach the array on write.
  assign cur_word = in_range ? mem_q[bus.ADR] : '0;
  assign new_word = merge_word(cur_word, bus.D, expand_mask(bus.WEM));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (state_q == S_INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST_ADR) begin
        state_q <= S_READY;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (init_wr) mem_q[cnt_q] <= INIT_VAL;
    else if (wr_en) mem_q[bus.ADR] <= new_word;
  end

`ifdef EH2_RAM_PARITY_EN
  logic par_q [DEPTH];
  logic rd_perr;
  logic out_perr;
  logic perr_q;

  assign rd_perr = in_range && ((^cur_word) != par_q[bus.ADR]);

  always_ff @(posedge CLK) begin
    if (init_wr) par_q[cnt_q] <= ^INIT_VAL;
    else if (wr_en) par_q[bus.ADR] <= (^new_word) ^ bus.PERR_INJ;
  end
`endif

  // Stage p1: optional extra register for the two-cycle read path
  if (RD_LAT == 2) begin : g_lat2
    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;

    always_ff @(posedge CLK) begin
      if (RST) vld_p1 <= 1'b0;
      else     vld_p1 <= rd_en;
    end
    always_ff @(posedge CLK) begin
      if (rd_en) data_p1 <= cur_word;
    end
    assign out_vld  = vld_p1;
    assign out_data = data_p1;
`ifdef EH2_RAM_PARITY_EN
    logic perr_p1;
    always_ff @(posedge CLK) begin
      if (rd_en) perr_p1 <= rd_perr;
    end
    assign out_perr = perr_p1;
`endif
  end else begin : g_lat1
    assign out_vld  = rd_en;
    assign out_data = cur_word;
`ifdef EH2_RAM_PARITY_EN
    assign out_perr = rd_perr;
`endif
  end

  // Output stage: Q holds between completions, reset discards in-flight reads
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= 1'b0;
      q_q   <= '0;
    end else begin
      vld_q <= out_vld;
      if (out_vld) q_q <= out_data;
    end
  end

`ifdef EH2_RAM_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) perr_q <= 1'b0;
    else     perr_q <= out_vld && out_perr;
  end
  assign bus.PERR = perr_q;
`endif

  assign bus.Q         = q_q;
  assign bus.RD_VALID  = vld_q;
  assign bus.INIT_BUSY = busy_q;
  assign bus.INIT_DONE = done_q;
endmodule

// File: tb/tb_eh2_ram_be_init.sv
// Scoreboard bench for eh2_ram_be_init: a DEPTH=12/RD_LAT=2/byte-mask instance and a
// DEPTH=16/RD_LAT=1/bit-mask instance share one stimulus stream against an array model.
`timescale 1ns/1ps
module tb_eh2_ram_be_init;
  localparam int         W    = 32;
  localparam logic [W-1:0] IV = 32'h0000_005A;
  localparam int         DEP0 = 12;
  localparam int         DEP1 = 16;
  localparam int         LAT0 = 2;
  localparam int         LAT1 = 1;
`ifdef EH2_RAM_PARITY_EN
  localparam bit         PAR  = 1'b1;
`else
  localparam bit         PAR  = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic         me = 1'b0;
  logic         we = 1'b0;
  logic [3:0]   adr = '0;
  logic [W-1:0] d = '0;
  logic [3:0]   wem0 = '0;
  logic [W-1:0] wem1 = '0;
  logic         inj = 1'b0;
  logic         perr0, perr1;

  eh2_ram_be_init_if #(.DEPTH(DEP0), .WIDTH(W), .MASK_GRAN(8)) b0 ();
  eh2_ram_be_init_if #(.DEPTH(DEP1), .WIDTH(W), .MASK_GRAN(1)) b1 ();

  eh2_ram_be_init #(.DEPTH(DEP0), .WIDTH(W), .MASK_GRAN(8), .RD_LAT(LAT0), .INIT_VAL(IV))
    dut0 (.CLK(CLK), .RST(RST), .bus(b0.slave));
  eh2_ram_be_init #(.DEPTH(DEP1), .WIDTH(W), .MASK_GRAN(1), .RD_LAT(LAT1), .INIT_VAL(IV))
    dut1 (.CLK(CLK), .RST(RST), .bus(b1.slave));

  assign b0.ME = me;  assign b0.WE = we;  assign b0.ADR = adr;  assign b0.D = d;  assign b0.WEM = wem0;
  assign b1.ME = me;  assign b1.WE = we;  assign b1.ADR = adr;  assign b1.D = d;  assign b1.WEM = wem1;
`ifdef EH2_RAM_PARITY_EN
  assign b0.PERR_INJ = inj;  assign b1.PERR_INJ = inj;
  assign perr0 = b0.PERR;    assign perr1 = b1.PERR;
`else
  assign perr0 = 1'b0;       assign perr1 = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] data;
    logic         perr;
    int           due;
  } exp_t;

  exp_t         sb [2][$];
  logic [W-1:0] mm [2][16];
  logic         mp [2][16];
  logic [W-1:0] qh [2];
  int           rel [2];
  int           edge_n = 0;
  int           n_pass = 0;
  int           n_total = 0;

  function automatic int dep(input int k);
    return (k == 0) ? DEP0 : DEP1;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [W-1:0] bmask(input int k, input logic [3:0] w0, input logic [W-1:0] w1);
    logic [W-1:0] m;
    m = w1;
    if (k == 0) for (int i = 0; i < 4; i++) m[8*i +: 8] = w0[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: a word array per instance, cycles since reset release, pending reads.
  always @(posedge CLK) begin
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        rel[k] = 0;
        qh[k]  = '0;
        while (sb[k].size() > 0 && sb[k][$].due >= edge_n) void'(sb[k].pop_back());
        for (int a = 0; a < 16; a++) begin
          mm[k][a] = IV;
          mp[k][a] = ^IV;
        end
      end else if (rel[k] < dep(k)) begin
        rel[k]++;
      end else if (me) begin
        if (we) begin
          if (int'(adr) < dep(k)) begin
            logic [W-1:0] m;
            m = bmask(k, wem0, wem1);
            mm[k][adr] = (mm[k][adr] & ~m) | (d & m);
            mp[k][adr] = (^mm[k][adr]) ^ (PAR & inj);
          end
        end else begin
          exp_t e;
          e.due = edge_n + lat(k) - 1;
          if (int'(adr) < dep(k)) begin
            e.data = mm[k][adr];
            e.perr = PAR & ((^mm[k][adr]) != mp[k][adr]);
          end else begin
            e.data = '0;
            e.perr = 1'b0;
          end
          sb[k].push_back(e);
        end
      end
    end
  end

  task automatic mon(input int k, input logic vld, input logic [W-1:0] q,
                     input logic busy, input logic done, input logic perr);
    logic exp_vld;
    exp_t e;
    chk($sformatf("d%0d_init_busy@%0d", k, edge_n), W'(busy), W'(rel[k] < dep(k)));
    chk($sformatf("d%0d_init_done@%0d", k, edge_n), W'(done), W'(rel[k] >= dep(k)));
    exp_vld = (sb[k].size() > 0) && (sb[k][0].due == edge_n);
    chk($sformatf("d%0d_rd_valid@%0d", k, edge_n), W'(vld), W'(exp_vld));
    if (exp_vld) begin
      e = sb[k].pop_front();
      if (vld) begin
        chk($sformatf("d%0d_q@%0d", k, edge_n), q, e.data);
        qh[k] = e.data;
`ifdef EH2_RAM_PARITY_EN
        chk($sformatf("d%0d_perr@%0d", k, edge_n), W'(perr), W'(e.perr));
`endif
      end
    end else if (!vld) begin
      chk($sformatf("d%0d_q_hold@%0d", k, edge_n), q, qh[k]);
`ifdef EH2_RAM_PARITY_EN
      chk($sformatf("d%0d_perr_idle@%0d", k, edge_n), W'(perr), '0);
`endif
    end
  endtask

  always @(negedge CLK) begin
    mon(0, b0.RD_VALID, b0.Q, b0.INIT_BUSY, b0.INIT_DONE, perr0);
    mon(1, b1.RD_VALID, b1.Q, b1.INIT_BUSY, b1.INIT_DONE, perr1);
  end

  task automatic cyc(input logic m, input logic w, input logic [3:0] a, input logic [W-1:0] dd,
                     input logic [3:0] w0, input logic [W-1:0] w1, input logic ij);
    me = m;  we = w;  adr = a;  d = dd;  wem0 = w0;  wem1 = w1;  inj = ij;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] dd);
    cyc(1'b1, 1'b1, a, dd, 4'hF, '1, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    cyc(1'b1, 1'b0, a, '0, 4'h0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, '0, 4'h0, '0, 1'b0);
  endtask

  initial begin
    RST = 1'b1;
    idle(3);
    RST = 1'b0;
    // Accesses during init, including a full write to word 3 on the sixth init cycle
    for (int i = 0; i < 20; i++) begin
      if (i == 5) wr(4'd3, 32'h0000_01FF);
      else        rd(i[3:0]);
    end
    rd(4'd3);  rd(4'd0);  rd(4'd15);  rd(4'd11);
    wr(4'd5, 32'h0);
    cyc(1'b1, 1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101, 32'h00FF_00FF, 1'b0);
    rd(4'd5);
    cyc(1'b1, 1'b1, 4'd5, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    rd(4'd5);
    wr(4'd1, 32'h11);  wr(4'd2, 32'h22);  wr(4'd3, 32'h33);
    rd(4'd1);  rd(4'd2);  rd(4'd3);
    idle(4);
    wr(4'd13, 32'hDEAD_BEEF);  rd(4'd13);
    wr(4'd11, 32'hCAFE_F00D);  rd(4'd11);
    rd(4'd11);  wr(4'd11, 32'h1234_5678);  rd(4'd11);
    idle(3);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $urandom, 4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)));
    idle(3);
    // Reset one cycle after a read request, then a full re-clear
    wr(4'd1, 32'h7777_0001);
    rd(4'd1);
    RST = 1'b1;
    idle(2);
    RST = 1'b0;
    idle(17);
    rd(4'd1);  rd(4'd3);  rd(4'd10);
    cyc(1'b1, 1'b1, 4'd2, 32'h5555_0000, 4'hF, '1, 1'b1);
    rd(4'd2);
    cyc(1'b1, 1'b1, 4'd4, 32'h0F0F_0F0F, 4'hF, '1, 1'b0);
    rd(4'd4);
    idle(5);
    chk("d0_scoreboard_drained", W'(sb[0].size()), '0);
    chk("d1_scoreboard_drained", W'(sb[1].size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/eh2_ram_be_init.md
Name: eh2_ram_be_init

Overview:
- Parametrised single-port behavioural SRAM model for the EH2 memory wrappers (ICCM/DCCM/IC data/tag arrays).
- Generalises the fixed-size RAM and byte-enable RAM models into one block with:
  - configurable write-mask granularity
  - selectable read latency
  - non-power-of-2 depth support
  - a hardware initialisation sequencer that clears the array after reset, replacing testbench preloading.

Parameters:
- DEPTH, 4096, number of words; any value ≥2, power of 2 not required.
- WIDTH, 39, data bits per word.
- MASK_GRAN, 1, data bits per write-mask bit; WIDTH must be divisible by MASK_GRAN.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- INIT_VAL, 0, WIDTH-bit value written to every word by the init sequencer.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ME  in  1  memory enable.
- WE  in  1  write enable (1 = write, 0 = read when ME=1).
- ADR  in  $clog2(DEPTH)  word address.
- D  in  WIDTH  write data.
- WEM  in  WIDTH/MASK_GRAN  write mask; bit i covers D[i*MASK_GRAN +: MASK_GRAN].
- Q  out  WIDTH  read data.
- RD_VALID  out  1  one-cycle pulse when Q carries new read data.
- INIT_BUSY  out  1  init sequencer active; ME ignored.
- INIT_DONE  out  1  array initialised, accepting accesses.

Behaviour:
- Reset values: Q=0, RD_VALID=0, INIT_BUSY=1, INIT_DONE=0, init address counter=0, read pipeline empty. Array contents are not reset by RST directly.
- Init FSM, states INIT and READY; RST forces INIT.
  - INIT: each cycle with RST=0, write INIT_VAL to word[cnt], then cnt++.
  - The cycle that writes word DEPTH-1 transitions to READY.
  - INIT_BUSY=1 and INIT_DONE=0 throughout INIT.
  - First access is accepted exactly DEPTH cycles after the first cycle with RST=0.
- READY: INIT_BUSY=0, INIT_DONE=1; the FSM stays in READY until RST.
- RST asserted mid-init or mid-operation:
  - FSM returns to INIT and cnt=0.
  - Any in-flight read is discarded: RD_VALID=0 and Q=0 next cycle.
  - Full re-clear follows.
- Accesses are ignored (no write, no read, no RD_VALID) while INIT_BUSY=1.
- Write (READY, ME=1, WE=1):
  - word[ADR] masked bits take D; unmasked bits keep old value.
  - WEM all-zero is a no-op.
  - Write is visible to a read issued the next cycle.
  - No RD_VALID; Q holds.
- Read (READY, ME=1, WE=0):
  - Q = word[ADR] and RD_VALID=1 exactly RD_LAT cycles after the request edge.
  - One read per cycle; fully pipelined when RD_LAT=2.
- Q holds its last read value whenever no read completes. RD_VALID=0 in those cycles.
- ME=0: no array activity.
- Out-of-range ADR (ADR ≥ DEPTH, only possible when DEPTH is not a power of 2):
  - Write is dropped.
  - Read returns all-zero Q with RD_VALID=1 at normal latency.
- Read followed immediately by a write to the same address: the read returns old data (read is captured at its request edge).

Optional Feature:
- Macro: EH2_RAM_PARITY_EN.
- When defined:
  - Each word stores one extra even-parity bit over the full WIDTH word after masking.
  - Init writes the parity of INIT_VAL.
  - Added ports:
    - PERR_INJ  in  1: when 1 during a write, stores inverted parity.
    - PERR  out  1: reset 0; asserts together with RD_VALID when the stored parity mismatches Q.
  - Out-of-range reads give PERR=0.
- When undefined: no parity storage; PERR_INJ/PERR ports absent; behaviour otherwise identical.

Test Plan:
- Init clear: DEPTH=16, INIT_VAL=0x5A, release RST at cycle 0.
  - INIT_BUSY=1 for cycles 0-15; INIT_DONE=1 from cycle 16.
  - Reads of ADR 0 and 15 return 0x5A.
- Access during init: write D=0x1FF to ADR 3 at cycle 5 of init.
  - Ignored; read of ADR 3 after INIT_DONE returns INIT_VAL.
  - No RD_VALID during init.
- Masked write: WIDTH=32, MASK_GRAN=8, word=0x00000000, write D=0xAABBCCDD with WEM=4'b0101.
  - Readback 0x00BB00DD.
  - WEM=0 then leaves it unchanged.
- Latency/pipeline: RD_LAT=2, back-to-back reads of ADR 1, 2, 3 holding 0x11, 0x22, 0x33.
  - RD_VALID high 3 consecutive cycles starting 2 cycles after the first request; Q = 0x11, 0x22, 0x33.
  - Q holds 0x33 afterwards.
- Non-power-of-2: DEPTH=12.
  - Write to ADR 13 is dropped; read of ADR 13 gives Q=0 with RD_VALID.
  - ADR 11 is writable and readable.
- Reset mid-operation: assert RST the cycle after a read request (RD_LAT=2).
  - No RD_VALID; Q=0.
  - INIT_BUSY reasserts; array re-cleared to INIT_VAL.
  - With EH2_RAM_PARITY_EN, a write with PERR_INJ=1 gives PERR=1 on readback.
